multiply_accumulate_stage: RTL and testbench

//  Sequential reduction stage directly downstream of the multiplyN blocks.
//  - Consumes a stream of truncated WIDTH-bit products over a valid/ready handshake.
//  - Sums TERMS consecutive products into an ACC_WIDTH-bit accumulator.
//  - Presents each completed sum, plus an overflow flag, on a valid/ready output.
//  - Use: dot-product / FIR reduction behind a combinational multiplier.

---
 rtl/multiply_accumulate_stage.sv | 115 +++++++++++
 tb/tb_multiply_accumulate_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_accumulate_stage.sv
// Sums TERMS consecutive unsigned products and hands each total downstream over valid/ready.
// Optional saturation instead of wrap-around: define MULTIPLY_ACCUMULATE_SAT_EN.
module multiply_accumulate_stage #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int TERMS     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_prod,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH-1:0]           out_sum,
    output logic                           out_ovf,
    output logic [$clog2(TERMS+1)-1:0]     count
);

    localparam int CW = $clog2(TERMS + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [ACC_WIDTH-1:0]   acc, acc_next;
    logic                   ovf, ovf_next;
    logic [CW-1:0]          count_next;
    logic [ACC_WIDTH-1:0]   out_sum_next;
    logic                   out_ovf_next;

    logic [ACC_WIDTH:0]     sum;
    logic                   carry;
    logic [ACC_WIDTH-1:0]   sum_fit;
    logic                   last;

    // One spare bit catches the carry out of the accumulator.
    assign sum   = {1'b0, acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_prod};
    assign carry = sum[ACC_WIDTH];

`ifdef MULTIPLY_ACCUMULATE_SAT_EN
    // A saturated acc plus any nonzero product carries again, so it stays pinned.
    assign sum_fit = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign sum_fit = sum[ACC_WIDTH-1:0];
`endif

    assign last      = (count == CW'(TERMS - 1));
    assign in_ready  = (state == ACCUM) && !clear;
    assign out_valid = (state == DONE);

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        ovf_next     = ovf;
        count_next   = count;
        out_sum_next = out_sum;
        out_ovf_next = out_ovf;

        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            ovf_next   = 1'b0;
            count_next = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (last) begin
                            out_sum_next = sum_fit;
                            out_ovf_next = ovf | carry;
                            state_next   = DONE;
                        end else begin
                            acc_next   = sum_fit;
                            ovf_next   = ovf | carry;
                            count_next = count + CW'(1);
                        end
                    end
                end
                DONE: begin
                    // The transfer cycle itself is a bubble: in_ready is 0 in DONE.
                    if (out_ready) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        ovf_next   = 1'b0;
                        count_next = '0;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ACCUM;
            acc     <= '0;
            ovf     <= 1'b0;
            count   <= '0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            ovf     <= ovf_next;
            count   <= count_next;
            out_sum <= out_sum_next;
            out_ovf <= out_ovf_next;
        end
    end

endmodule

// File: tb/tb_multiply_accumulate_stage.sv
// Bench for multiply_accumulate_stage: directed table, random run against a queue model,
// a narrow-accumulator overflow case and a TERMS=1 instance.
module tb_multiply_accumulate_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default instance: WIDTH=8, ACC_WIDTH=16, TERMS=4
    logic        a_reset, a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [7:0]  a_in_prod;
    logic [15:0] a_out_sum;
    logic [2:0]  a_count;

    // Narrow accumulator instance: ACC_WIDTH=9
    logic        bc_reset;
    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [7:0]  b_in_prod;
    logic [8:0]  b_out_sum;
    logic [2:0]  b_count;

    // Single-term instance: TERMS=1
    logic        c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic [7:0]  c_in_prod;
    logic [15:0] c_out_sum;
    logic [0:0]  c_count;

    multiply_accumulate_stage #(.WIDTH(8), .ACC_WIDTH(16), .TERMS(4)) dut_a (
        .clk(clk), .reset(a_reset), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_prod(a_in_prod), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
        .out_ovf(a_out_ovf), .count(a_count));

    multiply_accumulate_stage #(.WIDTH(8), .ACC_WIDTH(9), .TERMS(4)) dut_b (
        .clk(clk), .reset(bc_reset), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_prod(b_in_prod), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_ovf(b_out_ovf), .count(b_count));

    multiply_accumulate_stage #(.WIDTH(8), .ACC_WIDTH(16), .TERMS(1)) dut_c (
        .clk(clk), .reset(bc_reset), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_prod(c_in_prod), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sum(c_out_sum),
        .out_ovf(c_out_ovf), .count(c_count));

    typedef struct {
        logic        rst, clr, v;
        logic [7:0]  p;
        logic        ordy;
        logic        ir, ov;
        logic        chk_cnt;
        logic [2:0]  cnt;
        logic        chk_sum;
        logic [15:0] sum;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic clr, input logic v, input logic [7:0] p,
                       input logic ordy, input logic ir, input logic ov, input logic chk_cnt,
                       input logic [2:0] cnt, input logic chk_sum, input logic [15:0] sum,
                       input logic ovf);
        vec_t r;
        r.rst = rst; r.clr = clr; r.v = v; r.p = p; r.ordy = ordy; r.ir = ir; r.ov = ov;
        r.chk_cnt = chk_cnt; r.cnt = cnt; r.chk_sum = chk_sum; r.sum = sum; r.ovf = ovf;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result of a whole group from plain arithmetic: total, then wrap or clamp.
    function automatic void ref_result(input int total, input int aw, output int s, output bit o);
        int lim;
        lim = 1 << aw;
        o = (total >= lim);
`ifdef MULTIPLY_ACCUMULATE_SAT_EN
        s = o ? lim - 1 : total;
`else
        s = total % lim;
`endif
    endfunction

    initial begin
        int q[$];
        bit pend;
        int exp_s;
        bit exp_o;
        int tot;
        bit v, clr, ordy;
        logic [7:0] p;
        int cres[3];

        a_reset = 1; a_clear = 0; a_in_valid = 0; a_in_prod = 0; a_out_ready = 0;
        bc_reset = 1;
        b_clear = 0; b_in_valid = 0; b_in_prod = 0; b_out_ready = 0;
        c_clear = 0; c_in_valid = 0; c_in_prod = 0; c_out_ready = 0;
        repeat (2) @(negedge clk);
        a_reset = 0; bc_reset = 0;

        // Basic 10,20,30,40 -> 100
        for (int i = 0; i < 4; i++) add(0, 0, 1, 8'(10 * (i + 1)), 1, 1, 0, 1, 3'(i), 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 100, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // Backpressure: 255 x4, held for 5 cycles while in_valid stays high
        for (int i = 0; i < 4; i++) add(0, 0, 1, 255, 0, 1, 0, 1, 3'(i), 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 255, 0, 0, 1, 0, 0, 1, 1020, 0);
        add(0, 0, 1, 255, 1, 0, 1, 0, 0, 1, 1020, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // Clear mid-run drops 5,6 and refuses the 7
        add(0, 0, 1, 5, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 6, 0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 7, 0, 0, 0, 1, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 1, 0, 1, 3'(i), 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 4, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // Clear beats out_ready while a result of 8 is held
        for (int i = 0; i < 4; i++) add(0, 0, 1, 2, 0, 1, 0, 1, 3'(i), 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 8, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        // Reset after two products, then 3 x4 -> 12
        add(0, 0, 1, 3, 0, 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 3, 0, 1, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 3, 0, 1, 0, 1, 2, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 3, 0, 1, 0, 1, 3'(i), 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 12, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            a_reset = tbl[i].rst; a_clear = tbl[i].clr; a_in_valid = tbl[i].v;
            a_in_prod = tbl[i].p; a_out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d in_ready", i), a_in_ready, tbl[i].ir);
            chk($sformatf("tbl%0d out_valid", i), a_out_valid, tbl[i].ov);
            if (tbl[i].chk_cnt) chk($sformatf("tbl%0d count", i), a_count, tbl[i].cnt);
            if (tbl[i].chk_sum) begin
                chk($sformatf("tbl%0d out_sum", i), a_out_sum, tbl[i].sum);
                chk($sformatf("tbl%0d out_ovf", i), a_out_ovf, tbl[i].ovf);
            end
            @(negedge clk);
        end
        a_reset = 0;

        // Random run: the model only keeps the accepted products and a pending-result flag.
        pend = 0; exp_s = 0; exp_o = 0;
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom % 4) != 0;
            p    = 8'($urandom);
            clr  = ($urandom % 25) == 0;
            ordy = ($urandom % 3) != 0;
            a_in_valid = v; a_in_prod = p; a_clear = clr; a_out_ready = ordy;
            #1;
            chk("rnd in_ready", a_in_ready, !pend && !clr);
            chk("rnd out_valid", a_out_valid, pend);
            if (!pend) chk("rnd count", a_count, q.size());
            if (pend) begin
                chk("rnd out_sum", a_out_sum, exp_s);
                chk("rnd out_ovf", a_out_ovf, exp_o);
            end
            if (clr) begin
                q.delete(); pend = 0;
            end else if (pend) begin
                if (ordy) begin q.delete(); pend = 0; end
            end else if (v) begin
                q.push_back(int'(p));
                if (q.size() == 4) begin
                    tot = 0;
                    foreach (q[k]) tot += q[k];
                    ref_result(tot, 16, exp_s, exp_o);
                    pend = 1;
                end
            end
            @(negedge clk);
        end
        a_clear = 0; a_in_valid = 0; a_out_ready = 0;

        // Narrow accumulator: 255 x4 overflows 9 bits
        b_in_valid = 1; b_in_prod = 255; b_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ovf in_ready", b_in_ready, 1);
            chk("ovf count", b_count, i);
            @(negedge clk);
        end
        b_in_valid = 0;
        #1;
        ref_result(1020, 9, exp_s, exp_o);
        chk("ovf out_valid", b_out_valid, 1);
        chk("ovf out_sum", b_out_sum, exp_s);
        chk("ovf out_ovf", b_out_ovf, exp_o);
        @(negedge clk);
        #1;
        chk("ovf after xfer out_valid", b_out_valid, 0);
        chk("ovf after xfer in_ready", b_in_ready, 1);

        // TERMS=1: continuous in_valid, one accept every other cycle
        cres[0] = 9; cres[1] = 8; cres[2] = 7;
        @(negedge clk);
        c_in_valid = 1; c_out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) c_in_prod = 8'(cres[k / 2]);
            #1;
            chk($sformatf("t1 c%0d in_ready", k), c_in_ready, (k % 2) == 0);
            chk($sformatf("t1 c%0d out_valid", k), c_out_valid, (k % 2) == 1);
            chk($sformatf("t1 c%0d count", k), c_count, 0);
            if (k % 2 == 1) begin
                chk($sformatf("t1 c%0d out_sum", k), c_out_sum, cres[k / 2]);
                chk($sformatf("t1 c%0d out_ovf", k), c_out_ovf, 0);
            end
            @(negedge clk);
        end
        c_in_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
